regfile_wb: RTL and testbench
=============================

Name: regfile_wb

Overview:
Integer register file and writeback stage for the RV32I datapath. It feeds the ALU:
- the two combinational read ports drive rs1_val and rs2_val;
- the write port consumes the ALU's rd_write_control and rd_write_val, together with the destination address from decode.

After reset, an internal sequencer clears all architectural registers before the stage accepts traffic. A wrapping counter tracks committed writes.

Parameters:
XLEN, 32, data width of each register and each port.
NREGS, 32, number of architectural registers; x0 is hardwired to zero.
AW, $clog2(NREGS), register address width; derived, never overridden.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
rs1_addr  input  AW  read port 1 address
rs2_addr  input  AW  read port 2 address
rs1_val  output  XLEN  read port 1 data, combinational
rs2_val  output  XLEN  read port 2 data, combinational
wb_valid  input  1  a writeback is presented this cycle
wb_rd_addr  input  AW  destination register
rd_write_control  input  1  ALU write-enable
rd_write_val  input  XLEN  ALU result
ready  output  1  init complete; writes accepted and reads valid
wb_count  output  32  number of committed writes, wraps

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named rst. It is sampled only on the rising edge of clk.
- Reset values:
  - state=INIT, init_idx=1, ready=0, wb_count=0.
  - Register contents are not reset directly; the INIT sequence clears them.
- State machine (INIT, READY):
  - INIT: each clock, mem[init_idx]<=0. If init_idx==NREGS-1, go to READY; else init_idx++.
  - With NREGS=32, ready rises after exactly 31 rising edges with rst low.
  - READY is terminal until rst.
- Reset mid-INIT or in READY: restart INIT from init_idx=1 with wb_count=0. Prior contents are overwritten by the clear.
- Commit condition: a write commits on the edge when ready && wb_valid && rd_write_control && wb_rd_addr!=0.
  - On commit: mem[wb_rd_addr]<=rd_write_val and wb_count<=wb_count+1.
  - wb_count wraps from 0xFFFFFFFF to 0.
- Ignored writes: any write whose address is 0, whose rd_write_control is 0, or which arrives while ready==0 is dropped and not counted.
- Reads:
  - rsN_val = 0 when rsN_addr==0 or ready==0; otherwise mem[rsN_addr].
  - Both ports may read the same address.
  - Without bypass, a committed value is visible on the reads in the cycle after the commit edge.
- Simultaneous events: rst takes priority over commit in the same cycle. The init write and a writeback never collide, because writeback is blocked while ready==0.
- Width rules: no arithmetic on data; wb_count is an unsigned 32-bit increment.

Optional Feature:
REGFILE_WB_BYPASS_EN
- Defined: same-cycle forwarding. If a commit condition holds and wb_rd_addr==rsN_addr (nonzero), rsN_val = rd_write_val combinationally, in the same cycle as the write.
- Undefined: no forwarding; behaviour exactly as in Behaviour.

Decomposition:
- Shared package (alongside processor_defines): XLEN, NREGS, REG_ADDR_W, and the regfile_state_t enum {INIT, READY}.
- One sub-module is natural: regfile_read_port, instantiated twice. It contains the address-zero, ready-gating and, under the macro, the bypass mux.
- The storage array and FSM remain in regfile_wb.

Test Plan:
- Init timing: assert rst 2 cycles, release -> ready=0 for 31 edges, ready=1 after the 31st; all rs reads return 0 throughout.
- Basic write/read: write x5=0xDEADBEEF with wb_valid=1, rd_write_control=1 -> next cycle rs1_addr=5 gives 0xDEADBEEF; wb_count=1.
- x0 and disabled writes:
  - write x0=0x1234 -> rs1_val at addr 0 reads 0, wb_count unchanged;
  - rd_write_control=0 to x7 -> x7 stays 0.
- Write during INIT: present write x3=0xAA at cycle 10 after reset release -> dropped; x3 reads 0 once ready, wb_count=0.
- Mid-operation reset: fill x1..x31 with index values, pulse rst -> ready=0, and after re-init every register reads 0 and wb_count=0.
- Bypass and wrap:
  - with REGFILE_WB_BYPASS_EN, write x9=0x55 while rs2_addr=9 -> rs2_val=0x55 the same cycle (next cycle without the macro);
  - force wb_count=0xFFFFFFFF, one commit -> 0.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// Shared constants and state type for the RV32I integer register file / writeback stage.
package regfile_wb_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = $clog2(NREGS);

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } regfile_state_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: x0 and not-ready reads return zero; with
// REGFILE_WB_BYPASS_EN defined, a same-cycle commit to this address is forwarded.
module regfile_read_port #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            ready,
  input  logic [AW-1:0]   rs_addr,
  input  logic [XLEN-1:0] mem_data,
`ifdef REGFILE_WB_BYPASS_EN
  input  logic            byp_en,
  input  logic [AW-1:0]   byp_addr,
  input  logic [XLEN-1:0] byp_data,
`endif
  output logic [XLEN-1:0] rs_val
);

  always_comb begin
    rs_val = mem_data;
`ifdef REGFILE_WB_BYPASS_EN
    if (byp_en && (byp_addr == rs_addr)) begin
      rs_val = byp_data;
    end
`endif
    // Gating comes last so x0 and the not-ready window always read zero.
    if (!ready || (rs_addr == '0)) begin
      rs_val = '0;
    end
  end

endmodule

// File: rtl/regfile_wb.sv
// Register file plus writeback stage: clears x1..x(NREGS-1) after reset, then
// accepts ALU writebacks and counts them. Optional forwarding: REGFILE_WB_BYPASS_EN.
module regfile_wb #(
  parameter int  XLEN  = regfile_wb_pkg::XLEN,
  parameter int  NREGS = regfile_wb_pkg::NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] rs2_val,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd_addr,
  input  logic            rd_write_control,
  input  logic [XLEN-1:0] rd_write_val,
  output logic            ready,
  output logic [31:0]     wb_count
);

  import regfile_wb_pkg::*;

  regfile_state_t  state_q, state_d;
  logic [AW-1:0]   init_idx_q, init_idx_d;
  logic [31:0]     wb_count_q, wb_count_d;
  logic [XLEN-1:0] mem_q [NREGS];

  logic            commit;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  assign ready    = (state_q == READY);
  assign wb_count = wb_count_q;
  assign commit   = ready && wb_valid && rd_write_control && (wb_rd_addr != '0);

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    wb_count_d = wb_count_q;
    mem_we     = 1'b0;
    mem_waddr  = wb_rd_addr;
    mem_wdata  = rd_write_val;
    if (rst) begin
      state_d    = INIT;
      init_idx_d = AW'(1);
      wb_count_d = '0;
    end else if (state_q == INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_idx_q;
      mem_wdata = '0;
      if (init_idx_q == AW'(NREGS - 1)) begin
        state_d = READY;
      end else begin
        init_idx_d = init_idx_q + AW'(1);
      end
    end else if (commit) begin
      mem_we     = 1'b1;
      wb_count_d = wb_count_q + 32'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      init_idx_q <= AW'(1);
      wb_count_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      wb_count_q <= wb_count_d;
    end
  end

  // NOTE: the array has no reset; the INIT sweep clears it, which keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  regfile_read_port #(.XLEN(XLEN), .AW(AW)) u_rd1 (
    .ready    (ready),
    .rs_addr  (rs1_addr),
    .mem_data (mem_q[rs1_addr]),
`ifdef REGFILE_WB_BYPASS_EN
    .byp_en   (commit),
    .byp_addr (wb_rd_addr),
    .byp_data (rd_write_val),
`endif
    .rs_val   (rs1_val)
  );

  regfile_read_port #(.XLEN(XLEN), .AW(AW)) u_rd2 (
    .ready    (ready),
    .rs_addr  (rs2_addr),
    .mem_data (mem_q[rs2_addr]),
`ifdef REGFILE_WB_BYPASS_EN
    .byp_en   (commit),
    .byp_addr (wb_rd_addr),
    .byp_data (rd_write_val),
`endif
    .rs_val   (rs2_val)
  );

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: random traffic against an array-based
// reference model, plus directed init, x0, reset, bypass and wrap scenarios.
module tb_regfile_wb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   rs1_addr, rs2_addr, wb_rd_addr;
  logic [XLEN-1:0] rs1_val, rs2_val, rd_write_val;
  logic            wb_valid, rd_write_control, ready;
  logic [31:0]     wb_count;

  regfile_wb dut (
    .clk              (clk),
    .rst              (rst),
    .rs1_addr         (rs1_addr),
    .rs2_addr         (rs2_addr),
    .rs1_val          (rs1_val),
    .rs2_val          (rs2_val),
    .wb_valid         (wb_valid),
    .wb_rd_addr       (wb_rd_addr),
    .rd_write_control (rd_write_control),
    .rd_write_val     (rd_write_val),
    .ready            (ready),
    .wb_count         (wb_count)
  );

  always #5 clk = ~clk;

  // Reference model: register contents, edges since reset, readiness, commit count.
  logic [XLEN-1:0] mem_m [NREGS];
  int              init_edges_m;
  bit              ready_m;
  logic [31:0]     count_m;
  bit              chk_en = 1'b0;

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", tag, $time, got, exp);
    end
  endtask

  function automatic bit model_commit();
    return ready_m && wb_valid && rd_write_control && (wb_rd_addr != 0);
  endfunction

  function automatic logic [XLEN-1:0] model_read(input logic [AW-1:0] a);
    if (!ready_m || a == 0) return '0;
`ifdef REGFILE_WB_BYPASS_EN
    if (model_commit() && wb_rd_addr == a) return rd_write_val;
`endif
    return mem_m[a];
  endfunction

  // One clock: drive after the falling edge, check mid-low phase, update model at the rising edge.
  task automatic cycle(input bit r, input bit wv, input logic [AW-1:0] wa, input bit wc,
                       input logic [XLEN-1:0] wd, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    bit do_commit;
    @(negedge clk);
    rst = r; wb_valid = wv; wb_rd_addr = wa; rd_write_control = wc; rd_write_val = wd;
    rs1_addr = a1; rs2_addr = a2;
    #1;
    if (chk_en) begin
      check("ready", 32'(ready), 32'(ready_m));
      check("wb_count", wb_count, count_m);
      check("rs1_val", rs1_val, model_read(a1));
      check("rs2_val", rs2_val, model_read(a2));
    end
    do_commit = model_commit();
    @(posedge clk);
    if (r) begin
      init_edges_m = 0;
      ready_m      = 1'b0;
      count_m      = '0;
      for (int i = 0; i < NREGS; i++) mem_m[i] = '0;
      chk_en = 1'b1;
    end else if (!ready_m) begin
      init_edges_m++;
      if (init_edges_m == NREGS - 1) ready_m = 1'b1;
    end else if (do_commit) begin
      mem_m[wa] = wd;
      count_m   = count_m + 32'd1;
    end
  endtask

  task automatic idle(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    cycle(1'b0, 1'b0, '0, 1'b0, '0, a1, a2);
  endtask

  task automatic write(input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    cycle(1'b0, 1'b1, wa, 1'b1, wd, a1, a2);
  endtask

  task automatic reset_and_init();
    cycle(1'b1, 1'b0, '0, 1'b0, '0, '0, '0);
    cycle(1'b1, 1'b0, '0, 1'b0, '0, 5'd3, 5'd7);
    for (int i = 0; i < NREGS - 1; i++) begin
      if (i == 10) cycle(1'b0, 1'b1, 5'd3, 1'b1, 32'hAA, 5'd3, AW'($urandom_range(0, NREGS - 1)));
      else         cycle(1'b0, 1'($urandom), AW'($urandom), 1'($urandom), $urandom,
                         AW'($urandom), AW'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1; wb_valid = 1'b0; wb_rd_addr = '0; rd_write_control = 1'b0;
    rd_write_val = '0; rs1_addr = '0; rs2_addr = '0;

    // Init timing, with a write attempt at cycle 10 that must be dropped.
    reset_and_init();
    idle(5'd3, 5'd3);
    check("ready_after_31", 32'(ready), 32'd1);
    check("count_after_init", wb_count, 32'd0);

    // Basic write / read-back.
    write(5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0);
    idle(5'd5, 5'd5);
    check("x5_readback", rs1_val, 32'hDEAD_BEEF);
    check("count_one", wb_count, 32'd1);

    // x0 write and disabled write are both dropped.
    write(5'd0, 32'h1234, 5'd0, 5'd0);
    cycle(1'b0, 1'b1, 5'd7, 1'b0, 32'h7777, 5'd7, 5'd0);
    idle(5'd0, 5'd7);
    check("x0_zero", rs1_val, 32'd0);
    check("x7_unwritten", rs2_val, 32'd0);
    check("count_unchanged", wb_count, 32'd1);

    // Bypass: write x9 while reading it on port 2.
    write(5'd9, 32'h55, 5'd1, 5'd9);
    idle(5'd9, 5'd9);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 3) != 0), AW'($urandom), 1'($urandom_range(0, 3) != 0),
            $urandom, AW'($urandom), ($urandom_range(0, 3) == 0) ? wb_rd_addr : AW'($urandom));
    end

    // Fill x1..x31 with their index, then reset mid-operation and re-init.
    for (int i = 1; i < NREGS; i++) write(AW'(i), 32'(i), AW'(i), AW'(i - 1));
    reset_and_init();
    for (int i = 0; i < NREGS; i += 2) idle(AW'(i), AW'(i + 1));
    check("count_after_rst", wb_count, 32'd0);

    // Reset arriving during INIT restarts the sweep.
    cycle(1'b1, 1'b0, '0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 12; i++) idle(5'd4, 5'd6);
    reset_and_init();
    write(5'd12, 32'hCAFE_F00D, 5'd12, 5'd12);

    // Counter wrap from all-ones.
    idle(5'd12, 5'd0);
    wb_valid = 1'b0;
    force dut.wb_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.wb_count_q;
    count_m = 32'hFFFF_FFFF;
    write(5'd20, 32'h0BAD_CAFE, 5'd20, 5'd12);
    idle(5'd20, 5'd12);
    check("count_wrapped", wb_count, 32'd0);
    check("x20_after_wrap", rs1_val, 32'h0BAD_CAFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
